// File: rtl/kernel_ad_pkg.sv
// Shared constants and types for the ADC acquisition sequencer.
package kernel_ad_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ABORTED = 2;
    localparam int unsigned STAT_CNT_LSB = 16;

    typedef enum logic [2:0] {StIdle, StArm, StConv, StWait, StPush} state_e;

endpackage

// File: rtl/kernel_ad_acq_ctrl_if.sv
// Avalon-MM register port plus the outgoing sample stream.
interface kernel_ad_acq_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;

    modport master (
        output address, chipselect, write_n, writedata, smp_ready,
        input  readdata, smp_data, smp_valid
    );

    modport slave (
        input  address, chipselect, write_n, writedata, smp_ready,
        output readdata, smp_data, smp_valid
    );
endinterface

// File: rtl/kernel_ad_period_timer.sv
// Saturating down-counter that enforces the minimum spacing between conversions.
module kernel_ad_period_timer #(
    parameter int unsigned PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    output logic             is_zero
);
    logic [PER_W-1:0] cnt_q, cnt_d;

    // The load cycle itself counts as the first decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val == '0) ? '0 : load_val - PER_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign is_zero = (cnt_q == '0);
endmodule

// File: rtl/kernel_ad_acq_ctrl.sv
// ADC acquisition sequencer: register file, conversion FSM and sample stream.
module kernel_ad_acq_ctrl
    import kernel_ad_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PER_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    kernel_ad_acq_ctrl_if.slave   bus,
    output logic                  ad_convst,
    input  logic                  ad_done,
    input  logic [DATA_W-1:0]     ad_data,
    output logic                  irq
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, target_q, cnt_q, cnt_inc;
    logic [PER_W-1:0]  period_q, period_sh_q, timer_val;
    logic [DATA_W-1:0] smp_data_q;
    logic              irq_en_q, done_q, aborted_q;
    logic              wr, wr_ctrl, wr_status, start_cmd, abort_cmd, start_ok;
    logic              busy, hs, last, timer_load, timer_zero, smp_valid;
    logic [31:0]       rdata;
    logic              unused_wdata;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
    assign wr_status = wr && (bus.address == ADDR_STATUS);
    assign abort_cmd = wr_ctrl & bus.writedata[CTRL_ABORT];
    assign start_cmd = wr_ctrl & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_ABORT];
    assign busy      = (state_q != StIdle);
    assign start_ok  = start_cmd && !busy && (count_q != '0);
    assign hs        = (state_q == StPush) && bus.smp_ready && !abort_cmd;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last      = hs && (cnt_inc == target_q);
    assign timer_val = (period_sh_q == '0) ? '0 : period_sh_q - PER_W'(1);
    assign unused_wdata = ^bus.writedata;

    kernel_ad_period_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .is_zero  (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ad_convst  = 1'b0;
        smp_valid  = 1'b0;
        timer_load = 1'b0;
        unique case (state_q)
            StIdle: if (start_ok) state_d = StArm;
            StArm:  if (timer_zero) state_d = StConv;
            StConv: begin
                ad_convst  = 1'b1;
                timer_load = 1'b1;
                state_d    = StWait;
            end
            StWait: if (ad_done) state_d = StPush;
            StPush: begin
                smp_valid = 1'b1;
                if (bus.smp_ready) state_d = last ? StIdle : StArm;
            end
            default: state_d = StIdle;
        endcase
        if (abort_cmd) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q    <= 1'b0;
            count_q     <= '0;
            period_q    <= '0;
            target_q    <= '0;
            period_sh_q <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            smp_data_q  <= '0;
        end else begin
            if (wr_ctrl) irq_en_q <= bus.writedata[CTRL_IRQ_EN];
            if (wr && bus.address == ADDR_COUNT)  count_q  <= bus.writedata[CNT_W-1:0];
            if (wr && bus.address == ADDR_PERIOD) period_q <= bus.writedata[PER_W-1:0];
            if (start_ok) begin
                target_q    <= count_q;
                period_sh_q <= period_q;
                cnt_q       <= '0;
            end else if (hs) begin
                cnt_q <= cnt_inc;
            end
            // Completion takes priority over a simultaneous software clear.
            if (last)                                      done_q <= 1'b1;
            else if (start_ok)                             done_q <= 1'b0;
            else if (wr_status && bus.writedata[STAT_DONE]) done_q <= 1'b0;
            if (abort_cmd && busy)                            aborted_q <= 1'b1;
            else if (wr_status && bus.writedata[STAT_ABORTED]) aborted_q <= 1'b0;
            if (state_q == StWait && ad_done) smp_data_q <= ad_data;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (bus.address)
            ADDR_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
            ADDR_STATUS: begin
                rdata[STAT_BUSY]              = busy;
                rdata[STAT_DONE]              = done_q;
                rdata[STAT_ABORTED]           = aborted_q;
                rdata[STAT_CNT_LSB +: CNT_W]  = cnt_q;
            end
            ADDR_COUNT:  rdata[CNT_W-1:0] = count_q;
            ADDR_PERIOD: rdata[PER_W-1:0] = period_q;
            default:     rdata = '0;
        endcase
    end

    assign bus.readdata  = rdata;
    assign bus.smp_data  = smp_data_q;
    assign bus.smp_valid = smp_valid;
    assign irq           = done_q & irq_en_q;
endmodule

// File: tb/tb_kernel_ad_acq_ctrl.sv
// Directed and randomized checks of the ADC sequencer against a transaction-level model.
module tb_kernel_ad_acq_ctrl;
    import kernel_ad_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ad_convst, ad_done, irq;
    logic [15:0] ad_data;

    kernel_ad_acq_ctrl_if #(.DATA_W(16)) bus ();

    kernel_ad_acq_ctrl #(.DATA_W(16), .CNT_W(16), .PER_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ad_convst (ad_convst),
        .ad_done   (ad_done),
        .ad_data   (ad_data),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // ADC and stream model: every produced conversion result must leave the stream in order.
    int unsigned cyc = 0;
    int unsigned adc_lat = 4;
    int unsigned due;
    bit          pend = 1'b0;
    logic [15:0] pend_val;
    int unsigned convst_q[$];
    int unsigned hs_q[$];
    logic [15:0] adc_q[$];
    logic [15:0] prod_q[$];
    logic [15:0] got_q[$];

    initial begin
        ad_done = 1'b0;
        ad_data = '0;
    end

    always @(posedge clk) begin
        if (ad_convst) begin
            convst_q.push_back(cyc);
            pend_val = (adc_q.size() != 0) ? adc_q.pop_front() : 16'($urandom);
            prod_q.push_back(pend_val);
            due  = cyc + adc_lat;
            pend = 1'b1;
        end
        if (pend && (cyc + 1 == due)) begin
            ad_done <= 1'b1;
            ad_data <= pend_val;
            pend = 1'b0;
        end else begin
            ad_done <= 1'b0;
            ad_data <= 16'($urandom);
        end
        if (bus.smp_valid && bus.smp_ready) begin
            got_q.push_back(bus.smp_data);
            hs_q.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        convst_q.delete(); hs_q.delete(); adc_q.delete(); prod_q.delete(); got_q.delete();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1 d = bus.readdata;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        peek(a, d);
    endtask

    task automatic wait_idle(input int unsigned budget, input bit rnd_ready, input string tag);
        logic [31:0] st;
        int unsigned n = 0;
        do begin
            @(negedge clk);
            if (rnd_ready) bus.smp_ready = 1'($urandom_range(1, 0));
            peek(ADDR_STATUS, st);
            n++;
        end while (st[STAT_BUSY] && n < budget);
        chk({tag, "_idle"}, 32'(st[STAT_BUSY]), 32'd0);
    endtask

    task automatic wait_valid(input int unsigned budget, input string tag);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.smp_valid && n < budget);
        chk({tag, "_valid"}, 32'(bus.smp_valid), 32'd1);
    endtask

    task automatic wait_size(input bit conv, input int unsigned want, input int unsigned budget,
                             input string tag);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((conv ? convst_q.size() : got_q.size()) < want && n < budget);
        chk({tag, "_reach"}, conv ? convst_q.size() : got_q.size(), want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] st;
        logic [15:0] first;
        int unsigned bad, cnt, per;
        logic [15:0] exp1[3];
        exp1[0] = 16'h1234; exp1[1] = 16'h5678; exp1[2] = 16'h9ABC;

        reset = 1'b1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus.writedata = '0; bus.smp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), st);
            chk($sformatf("reset_rd%0d", a), st, 32'd0);
        end
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_convst", 32'(ad_convst), 32'd0);
        chk("reset_valid", 32'(bus.smp_valid), 32'd0);

        // Basic run: three samples, period 10, ADC latency 4.
        clear_q();
        adc_lat = 4;
        adc_q.push_back(16'h1234); adc_q.push_back(16'h5678); adc_q.push_back(16'h9ABC);
        bus.smp_ready = 1'b1;
        bus_write(ADDR_COUNT, 32'd3);
        bus_write(ADDR_PERIOD, 32'd10);
        bus_write(ADDR_CTRL, 32'h5);
        wait_idle(300, 1'b0, "run1");
        chk("run1_nconv", convst_q.size(), 32'd3);
        if (convst_q.size() >= 3) begin
            chk("run1_gap0", convst_q[1] - convst_q[0], 32'd10);
            chk("run1_gap1", convst_q[2] - convst_q[1], 32'd10);
        end
        chk("run1_ngot", got_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("run1_data%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 'x,
                32'(exp1[i]));
        rd(ADDR_STATUS, st);
        chk("run1_status", st, 32'h0003_0002);
        chk("run1_irq", 32'(irq), 32'd1);
        bus_write(ADDR_STATUS, 32'h2);
        chk("run1_irq_clr", 32'(irq), 32'd0);

        // Backpressure on the first sample.
        clear_q();
        bus.smp_ready = 1'b0;
        bus_write(ADDR_COUNT, 32'd2);
        bus_write(ADDR_PERIOD, 32'd2);
        bus_write(ADDR_CTRL, 32'h5);
        wait_valid(60, "bp");
        first = bus.smp_data;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.smp_valid || bus.smp_data !== first) bad++;
        end
        chk("bp_hold", bad, 32'd0);
        chk("bp_stall_nconv", convst_q.size(), 32'd1);
        chk("bp_data0", 32'(first), (prod_q.size() != 0) ? 32'(prod_q[0]) : 'x);
        bus.smp_ready = 1'b1;
        wait_idle(100, 1'b0, "bp");
        chk("bp_nconv", convst_q.size(), 32'd2);
        if (convst_q.size() >= 2 && hs_q.size() >= 1)
            chk("bp_order", 32'(convst_q[1] > hs_q[0]), 32'd1);
        rd(ADDR_STATUS, st);
        chk("bp_status", st, 32'h0002_0002);

        // Abort while waiting on the second conversion.
        clear_q();
        adc_lat = 8;
        bus_write(ADDR_COUNT, 32'd3);
        bus_write(ADDR_PERIOD, 32'd1);
        bus_write(ADDR_CTRL, 32'h5);
        wait_size(1'b1, 2, 100, "ab_conv");
        repeat (2) @(negedge clk);
        bus_write(ADDR_CTRL, 32'h6);
        peek(ADDR_STATUS, st);
        chk("ab_status", st, 32'h0001_0004);
        chk("ab_valid", 32'(bus.smp_valid), 32'd0);
        chk("ab_ngot", got_q.size(), 32'd1);
        chk("ab_data", (got_q.size() != 0) ? 32'(got_q[0]) : 'x,
            (prod_q.size() != 0) ? 32'(prod_q[0]) : 'x);
        convst_q.delete();
        bus_write(ADDR_CTRL, 32'h7);
        repeat (30) @(negedge clk);
        chk("ab_start_nconv", convst_q.size(), 32'd0);
        peek(ADDR_STATUS, st);
        chk("ab_start_status", st, 32'h0001_0004);
        bus_write(ADDR_STATUS, 32'h4);
        peek(ADDR_STATUS, st);
        chk("ab_w1c", st, 32'h0001_0000);

        // START with a zero target is ignored.
        clear_q();
        adc_lat = 4;
        bus_write(ADDR_COUNT, 32'd0);
        bus_write(ADDR_CTRL, 32'h5);
        repeat (20) @(negedge clk);
        chk("zero_nconv", convst_q.size(), 32'd0);
        rd(ADDR_STATUS, st);
        chk("zero_status", st, 32'h0001_0000);

        // START while busy must not restart the run.
        clear_q();
        bus_write(ADDR_COUNT, 32'd2);
        bus_write(ADDR_PERIOD, 32'd20);
        bus_write(ADDR_CTRL, 32'h5);
        wait_size(1'b0, 1, 100, "sb_got");
        bus_write(ADDR_CTRL, 32'h5);
        wait_idle(200, 1'b0, "sb");
        chk("sb_nconv", convst_q.size(), 32'd2);
        rd(ADDR_STATUS, st);
        chk("sb_status", st, 32'h0002_0002);

        // COUNT rewritten mid-run only affects the next START.
        clear_q();
        bus_write(ADDR_COUNT, 32'd2);
        bus_write(ADDR_PERIOD, 32'd3);
        bus_write(ADDR_CTRL, 32'h5);
        bus_write(ADDR_COUNT, 32'd5);
        wait_idle(200, 1'b0, "mr");
        chk("mr_ngot", got_q.size(), 32'd2);
        rd(ADDR_COUNT, st);
        chk("mr_count", st, 32'd5);
        rd(ADDR_STATUS, st);
        chk("mr_status", st, 32'h0002_0002);

        // Second run of 5; W1C of DONE lands on the completing handshake.
        clear_q();
        bus_write(ADDR_CTRL, 32'h5);
        wait_size(1'b0, 4, 300, "race_got");
        bus.smp_ready = 1'b0;
        wait_valid(60, "race");
        @(negedge clk);
        bus.smp_ready = 1'b1;
        bus.address = ADDR_STATUS; bus.writedata = 32'h2;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        peek(ADDR_STATUS, st);
        chk("race_status", st, 32'h0005_0002);
        chk("race_ngot", got_q.size(), 32'd5);

        // Randomized runs with random backpressure.
        for (int it = 0; it < 6; it++) begin
            clear_q();
            cnt = $urandom_range(6, 1);
            per = $urandom_range(12, 0);
            adc_lat = $urandom_range(6, 1);
            bus_write(ADDR_COUNT, cnt);
            bus_write(ADDR_PERIOD, per);
            bus_write(ADDR_CTRL, 32'h5);
            wait_idle(1500, 1'b1, $sformatf("rnd%0d", it));
            bus.smp_ready = 1'b1;
            chk($sformatf("rnd%0d_nconv", it), convst_q.size(), cnt);
            chk($sformatf("rnd%0d_ngot", it), got_q.size(), cnt);
            bad = 0;
            for (int i = 0; i < got_q.size() && i < prod_q.size(); i++)
                if (got_q[i] !== prod_q[i]) bad++;
            for (int i = 1; i < convst_q.size(); i++) begin
                if (convst_q[i] - convst_q[i-1] < per) bad++;
                if (i - 1 >= hs_q.size() || convst_q[i] <= hs_q[i-1]) bad++;
            end
            chk($sformatf("rnd%0d_rules", it), bad, 32'd0);
            rd(ADDR_STATUS, st);
            chk($sformatf("rnd%0d_status", it), st, {16'(cnt), 16'h0002});
            chk($sformatf("rnd%0d_irq", it), 32'(irq), 32'd1);
        end

        // Reset during a stalled PUSH drops the sample.
        clear_q();
        bus.smp_ready = 1'b0;
        bus_write(ADDR_COUNT, 32'd2);
        bus_write(ADDR_PERIOD, 32'd0);
        bus_write(ADDR_CTRL, 32'h5);
        wait_valid(60, "rst");
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(bus.smp_valid), 32'd0);
        chk("rst_convst", 32'(ad_convst), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        bad = 0;
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), st);
            if (st !== 32'd0) bad++;
        end
        chk("rst_regs", bad, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/kernel_ad_acq_ctrl.md
Name: kernel_ad_acq_ctrl

Overview:
Avalon-MM-controlled acquisition sequencer for the external ADC. Software programs a sample count and a conversion period, then writes a start command. The block issues conversion strobes, waits for the ADC's done flag, and captures each 16-bit sample. Each sample goes out on a valid/ready stream to the downstream buffer, and the block raises done/irq when the programmed count is reached.

Parameters:
DATA_W, 16, ADC sample width.
CNT_W, 16, width of sample-count target and captured-count registers.
PER_W, 16, width of conversion period register.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
address  in  2  Avalon register select
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, combinational from address, zero wait states
ad_convst  out  1  ADC conversion start, one-cycle high pulse
ad_done  in  1  ADC conversion complete, level, sampled each cycle
ad_data  in  DATA_W  ADC result, valid while ad_done=1
smp_data  out  DATA_W  captured sample
smp_valid  out  1  sample available
smp_ready  in  1  downstream accepts sample
irq  out  1  done & irq_en

Behaviour:
- Clock, reset and read path:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - Readdata is a combinational mux; unused bits read 0.
- Register map (write = chipselect & ~write_n):
  - addr0 CTRL: wr bit0 START (pulse, not stored); wr bit1 ABORT (pulse); bit2 IRQ_EN (r/w).
  - addr1 STATUS: bit0 BUSY (ro); bit1 DONE (sticky, write 1 clears); bit2 ABORTED (sticky, write 1 clears); [31:16] captured count (ro).
  - addr2 COUNT: [CNT_W-1:0] target (r/w).
  - addr3 PERIOD: [PER_W-1:0] minimum cycles between ad_convst pulses (r/w).
- Reset values: all outputs and registers 0; state IDLE; ad_convst=0; smp_valid=0; irq=0.
- FSM states: IDLE, ARM, CONV, WAIT, PUSH.
  - IDLE -> ARM on START when target != 0. START also shadows target/period, clears captured count and clears DONE.
  - START with target=0 is ignored. START while BUSY is ignored.
  - ARM -> CONV when period counter == 0.
  - CONV: ad_convst=1 for exactly this cycle. Period counter loaded with shadowed period-1 (period 0 or 1 means back-to-back allowed). Always -> WAIT next cycle.
  - WAIT: on ad_done=1, latch ad_data into smp_data, -> PUSH.
  - PUSH: smp_valid=1. smp_data is held stable until smp_ready. On valid&ready, count+1.
    - If new count == target: -> IDLE, set DONE.
    - Otherwise -> ARM.
- Period counter: decrements by 1 per cycle in every state, saturating at 0. Period is therefore measured convst-to-convst, so conversion and stream backpressure time count toward it.
- BUSY = state != IDLE.
- Sample latency: ad_done high in WAIT -> smp_valid high on the next cycle.
- ABORT:
  - Any state -> IDLE next cycle; smp_valid drops; set ABORTED if BUSY; DONE unchanged.
  - ABORT and START in the same write: ABORT wins, no run starts.
- Register updates during a run: writes to COUNT/PERIOD while BUSY update the registers only; they take effect at the next START.
- DONE set and software W1C in the same cycle: set wins.
- Captured count never exceeds target; no wrap within a run.
- Reset asserted mid-run: next edge returns to full reset state. Any pending sample is dropped and ad_convst is low.

Decomposition:
- Shared package kernel_ad_pkg holds:
  - register address constants (ADDR_CTRL=0, ADDR_STATUS=1, ADDR_COUNT=2, ADDR_PERIOD=3);
  - CTRL/STATUS bit index constants;
  - state enum typedef.
- One natural sub-module: kernel_ad_period_timer (load/decrement/saturate counter, is_zero output).
- The register file and FSM stay in the top level.

Test Plan:
- Reset, then read all four addresses -> every readdata = 0; irq=0; ad_convst=0.
- COUNT=3, PERIOD=10, START; ADC model asserts ad_done 4 cycles after convst; smp_ready=1 -> expect:
  - 3 convst pulses exactly 10 cycles apart;
  - smp_data equals model values 0x1234, 0x5678, 0x9ABC;
  - STATUS=0x0003_0002 at end;
  - irq=1 if IRQ_EN.
- Backpressure: COUNT=2, PERIOD=2, smp_ready low 20 cycles on the first sample -> expect:
  - smp_valid held, smp_data stable;
  - second convst only after the handshake;
  - captured count=2.
- ABORT while in WAIT with count=1 -> expect:
  - IDLE next cycle, BUSY=0, ABORTED=1, DONE=0, STATUS[31:16]=1;
  - START+ABORT in one write -> no convst.
- START with COUNT=0 -> no convst, BUSY stays 0. START while BUSY -> count not cleared, run unaffected.
- COUNT rewritten to 5 mid-run of target 2 -> run ends at 2; next START runs 5. W1C of DONE in the same cycle as completion -> DONE reads 1.
